// File: rtl/fetch_controller.sv
// fetch_controller
// Fetch stage sequencer for a combinational instruction memory. It holds the
// PC, presents it as the memory address every cycle and buffers fetched words
// in a small prefetch queue. Decode takes them over a valid/ready handshake.
// Execute may redirect the PC at any time. Fetching stops at the end of the
// loaded program, and fim is raised once the queue has drained.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   mem_endereco  byte address to instruction memory (the current PC)
//   mem_instrucao word returned combinationally for mem_endereco
//   desvio_valido redirect request (one-cycle pulse)
//   desvio_alvo   redirect target byte address (low two bits ignored)
//   saida_valida  queue head holds a valid instruction
//   saida_pronta  decode accepts the head this cycle
//   instrucao     instruction at the queue head (0 when empty)
//   pc_saida      byte address of the queue head (0 when empty)
//   fim           program exhausted and queue empty
//   ocupacao      queue entry count, 0..QDEPTH
module fetch_controller #(
  parameter int PROG_WORDS = 13,
  parameter int RESET_PC   = 0,
  parameter int QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_endereco,
  input  logic [31:0] mem_instrucao,
  input  logic        desvio_valido,
  input  logic [31:0] desvio_alvo,
  output logic        saida_valida,
  input  logic        saida_pronta,
  output logic [31:0] instrucao,
  output logic [31:0] pc_saida,
  output logic        fim,
  output logic [2:0]  ocupacao
);

  localparam int          PW       = (QDEPTH > 2) ? 2 : 1;
  localparam logic [31:0] START_PC = 32'(RESET_PC);
  localparam logic [31:0] END_ADDR = START_PC + 32'(PROG_WORDS) * 32'd4;
  localparam logic [2:0]  QD       = 3'(QDEPTH);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [2:0]     occ_q, occ_d;
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic           fim_q, fim_d;
  logic [31:0]    pc_buf_q  [QDEPTH];
  logic [31:0]    pc_buf_d  [QDEPTH];
  logic [31:0]    ins_buf_q [QDEPTH];
  logic [31:0]    ins_buf_d [QDEPTH];

  logic pop;
  logic push;

  // Redirect targets are word aligned; the two low bits are dropped.
  logic unused_alvo_bits;
  assign unused_alvo_bits = ^desvio_alvo[1:0];

  always_comb begin
    pop  = (occ_q != 3'd0) && saida_pronta;
    // A full queue still accepts a word when the head leaves this cycle.
    push = ((state_q == S_RUN) || (state_q == S_STALL)) && (pc_q < END_ADDR) &&
           ((occ_q < QD) || pop) && !desvio_valido;

    state_d   = state_q;
    pc_d      = pc_q;
    occ_d     = occ_q;
    head_d    = head_q;
    tail_d    = tail_q;
    pc_buf_d  = pc_buf_q;
    ins_buf_d = ins_buf_q;

    if (desvio_valido) begin
      // Flush wins over any pop this cycle; pointers restart at slot 0.
      pc_d    = {desvio_alvo[31:2], 2'b00};
      occ_d   = 3'd0;
      head_d  = '0;
      tail_d  = '0;
      state_d = S_RUN;
    end else begin
      if (push) begin
        pc_buf_d[tail_q]  = pc_q;
        ins_buf_d[tail_q] = mem_instrucao;
        tail_d            = tail_q + PW'(1);
        pc_d              = pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      occ_d = occ_q + 3'(push) - 3'(pop);

      unique case (state_q)
        S_RUN, S_STALL: begin
          if (pc_d >= END_ADDR) begin
            state_d = (occ_d != 3'd0) ? S_DRAIN : S_DONE;
          end else if (state_q == S_RUN) begin
            if ((occ_d == QD) && !pop) state_d = S_STALL;
          end else if (occ_d < QD) begin
            state_d = S_RUN;
          end
        end
        S_DRAIN: begin
          if (occ_d == 3'd0) state_d = S_DONE;
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_RUN;
      endcase
    end

    // fim is registered alongside the state so it rises with DONE entry.
    fim_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RUN;
      pc_q      <= START_PC;
      occ_q     <= 3'd0;
      head_q    <= '0;
      tail_q    <= '0;
      fim_q     <= 1'b0;
      pc_buf_q  <= '{default: '0};
      ins_buf_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      occ_q     <= occ_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      fim_q     <= fim_d;
      pc_buf_q  <= pc_buf_d;
      ins_buf_q <= ins_buf_d;
    end
  end

  assign mem_endereco = pc_q;
  assign saida_valida = (occ_q != 3'd0);
  assign instrucao    = saida_valida ? ins_buf_q[head_q] : 32'd0;
  assign pc_saida     = saida_valida ? pc_buf_q[head_q] : 32'd0;
  assign fim          = fim_q;
  assign ocupacao     = occ_q;

endmodule
